// File: rtl/yutorina_operand_fetch_pkg.sv
// Yutorina operand fetch: shared types and constants.
// Active-low enables follow the GPR write port polarity.
package yutorina_operand_fetch_pkg;

  localparam int GPR_NUM     = 32;
  localparam int GPR_ADDR_W  = 5;
  localparam int WORD_DATA_W = 32;
  localparam int STALL_CNT_W = 16;

  typedef logic [GPR_ADDR_W-1:0]  GprAddrBus;
  typedef logic [WORD_DATA_W-1:0] WordDataBus;
  typedef logic [STALL_CNT_W-1:0] StallCntBus;

  localparam GprAddrBus GPR_ZERO = '0;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // reset is asserted low and taken on its falling edge
  localparam logic RESET_ENABLE = 1'b0;
  localparam logic RESET_EDGE   = 1'b0;

  typedef struct packed {
    logic       en;
    WordDataBus ra_data;
    WordDataBus rb_data;
    GprAddrBus  dst_addr;
    logic       dst_we_;
    logic       is_load;
  } id_ex_t;

  function automatic logic src_hit(
    input logic      en,
    input logic      we_,
    input GprAddrBus dst,
    input GprAddrBus src
  );
    return en && (we_ == ENABLE_) &&
           (dst == src) && (src != GPR_ZERO);
  endfunction

endpackage

// File: rtl/yutorina_operand_fetch_if.sv
// Yutorina operand fetch: decode, bypass, GPR and ID/EX bundle.
// slave is the fetch unit's view, master the surrounding pipeline.
interface yutorina_operand_fetch_if;
  import yutorina_operand_fetch_pkg::*;

  logic       id_en;
  GprAddrBus  id_ra_addr;
  GprAddrBus  id_rb_addr;
  logic       id_ra_use;
  logic       id_rb_use;
  GprAddrBus  id_dst_addr;
  logic       id_dst_we_;
  logic       id_is_load;

  GprAddrBus  gpr_rd_addr0;
  GprAddrBus  gpr_rd_addr1;
  WordDataBus gpr_rd_data0;
  WordDataBus gpr_rd_data1;

  logic       ex_en;
  logic       ex_dst_we_;
  logic       ex_is_load;
  GprAddrBus  ex_dst_addr;
  WordDataBus ex_fwd_data;

  logic       mem_en;
  logic       mem_dst_we_;
  GprAddrBus  mem_dst_addr;
  WordDataBus mem_fwd_data;

  logic       wb_we_;
  GprAddrBus  wb_addr;
  WordDataBus wb_data;

  logic       stall;
  logic       flush;
  logic       hazard_stall;

  logic       of_en;
  WordDataBus of_ra_data;
  WordDataBus of_rb_data;
  GprAddrBus  of_dst_addr;
  logic       of_dst_we_;
  logic       of_is_load;
  StallCntBus stall_cnt;

  modport slave (
    input  id_en, id_ra_addr, id_rb_addr,
    input  id_ra_use, id_rb_use,
    input  id_dst_addr, id_dst_we_, id_is_load,
    output gpr_rd_addr0, gpr_rd_addr1,
    input  gpr_rd_data0, gpr_rd_data1,
    input  ex_en, ex_dst_we_, ex_is_load,
    input  ex_dst_addr, ex_fwd_data,
    input  mem_en, mem_dst_we_,
    input  mem_dst_addr, mem_fwd_data,
    input  wb_we_, wb_addr, wb_data,
    input  stall, flush,
    output hazard_stall,
    output of_en, of_ra_data, of_rb_data,
    output of_dst_addr, of_dst_we_, of_is_load,
    output stall_cnt
  );

  modport master (
    output id_en, id_ra_addr, id_rb_addr,
    output id_ra_use, id_rb_use,
    output id_dst_addr, id_dst_we_, id_is_load,
    input  gpr_rd_addr0, gpr_rd_addr1,
    output gpr_rd_data0, gpr_rd_data1,
    output ex_en, ex_dst_we_, ex_is_load,
    output ex_dst_addr, ex_fwd_data,
    output mem_en, mem_dst_we_,
    output mem_dst_addr, mem_fwd_data,
    output wb_we_, wb_addr, wb_data,
    output stall, flush,
    input  hazard_stall,
    input  of_en, of_ra_data, of_rb_data,
    input  of_dst_addr, of_dst_we_, of_is_load,
    input  stall_cnt
  );

endinterface

// File: rtl/yutorina_fwd_mux.sv
// Yutorina operand bypass: one source operand, priority
// $0 > EX > MEM > WB > GPR read data.
module yutorina_fwd_mux
  import yutorina_operand_fetch_pkg::*;
(
  input  GprAddrBus  src,
  input  logic       ex_en,
  input  logic       ex_dst_we_,
  input  GprAddrBus  ex_dst_addr,
  input  WordDataBus ex_fwd_data,
  input  logic       mem_en,
  input  logic       mem_dst_we_,
  input  GprAddrBus  mem_dst_addr,
  input  WordDataBus mem_fwd_data,
  input  logic       wb_we_,
  input  GprAddrBus  wb_addr,
  input  WordDataBus wb_data,
  input  WordDataBus gpr_data,
  output WordDataBus data
);

  logic is_zero;
  logic ex_hit;
  logic mem_hit;
  logic wb_hit;
  logic sel_mem;
  logic sel_wb;

  assign is_zero = (src == GPR_ZERO);
  assign ex_hit  = src_hit(ex_en, ex_dst_we_,
                           ex_dst_addr, src);
  assign mem_hit = src_hit(mem_en, mem_dst_we_,
                           mem_dst_addr, src);
  assign wb_hit  = src_hit(1'b1, wb_we_, wb_addr, src);

  // one-hot selects; hits already exclude $0
  assign sel_mem = mem_hit & ~ex_hit;
  assign sel_wb  = wb_hit & ~ex_hit & ~mem_hit;

  always_comb begin
    data = gpr_data;
    unique case (1'b1)
      is_zero: data = '0;
      ex_hit:  data = ex_fwd_data;
      sel_mem: data = mem_fwd_data;
      sel_wb:  data = wb_data;
      default: data = gpr_data;
    endcase
  end

endmodule

// File: rtl/yutorina_operand_fetch.sv
// Yutorina operand fetch: GPR read, EX/MEM/WB bypass,
// load-use hazard detection and the ID/EX register.
module yutorina_operand_fetch
  import yutorina_operand_fetch_pkg::*;
(
  input logic                      clk,
  input logic                      rst,
  yutorina_operand_fetch_if.slave  bus
);

  WordDataBus ra_data;
  WordDataBus rb_data;
  logic       ld_pend;
  logic       ra_dep;
  logic       rb_dep;
  logic       hazard;
  id_ex_t     q;
  StallCntBus cnt;

  assign bus.gpr_rd_addr0 = bus.id_ra_addr;
  assign bus.gpr_rd_addr1 = bus.id_rb_addr;

  yutorina_fwd_mux u_fwd_ra (
    .src          (bus.id_ra_addr),
    .ex_en        (bus.ex_en),
    .ex_dst_we_   (bus.ex_dst_we_),
    .ex_dst_addr  (bus.ex_dst_addr),
    .ex_fwd_data  (bus.ex_fwd_data),
    .mem_en       (bus.mem_en),
    .mem_dst_we_  (bus.mem_dst_we_),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_fwd_data (bus.mem_fwd_data),
    .wb_we_       (bus.wb_we_),
    .wb_addr      (bus.wb_addr),
    .wb_data      (bus.wb_data),
    .gpr_data     (bus.gpr_rd_data0),
    .data         (ra_data)
  );

  yutorina_fwd_mux u_fwd_rb (
    .src          (bus.id_rb_addr),
    .ex_en        (bus.ex_en),
    .ex_dst_we_   (bus.ex_dst_we_),
    .ex_dst_addr  (bus.ex_dst_addr),
    .ex_fwd_data  (bus.ex_fwd_data),
    .mem_en       (bus.mem_en),
    .mem_dst_we_  (bus.mem_dst_we_),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_fwd_data (bus.mem_fwd_data),
    .wb_we_       (bus.wb_we_),
    .wb_addr      (bus.wb_addr),
    .wb_data      (bus.wb_data),
    .gpr_data     (bus.gpr_rd_data1),
    .data         (rb_data)
  );

  // a load in EX has no data yet, so any used match must wait
  assign ld_pend = bus.ex_en & bus.ex_is_load &
                   (bus.ex_dst_we_ == ENABLE_) &
                   (bus.ex_dst_addr != GPR_ZERO);
  assign ra_dep  = bus.id_ra_use &
                   (bus.id_ra_addr == bus.ex_dst_addr);
  assign rb_dep  = bus.id_rb_use &
                   (bus.id_rb_addr == bus.ex_dst_addr);
  assign hazard  = bus.id_en & ld_pend & (ra_dep | rb_dep);

  assign bus.hazard_stall = hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_ENABLE) begin
      q.en       <= 1'b0;
      q.ra_data  <= '0;
      q.rb_data  <= '0;
      q.dst_addr <= GPR_ZERO;
      q.dst_we_  <= DISABLE_;
      q.is_load  <= 1'b0;
    end else if (bus.flush) begin
      q.en      <= 1'b0;
      q.dst_we_ <= DISABLE_;
    end else if (bus.stall) begin
      q <= q;
    end else if (hazard) begin
      q.en      <= 1'b0;
      q.dst_we_ <= DISABLE_;
    end else begin
      q.en       <= bus.id_en;
      q.ra_data  <= ra_data;
      q.rb_data  <= rb_data;
      q.dst_addr <= bus.id_dst_addr;
      q.dst_we_  <= bus.id_dst_we_;
      q.is_load  <= bus.id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RESET_ENABLE) begin
      cnt <= '0;
    end else if (hazard & ~bus.stall & ~bus.flush &
                 (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.of_en       = q.en;
  assign bus.of_ra_data  = q.ra_data;
  assign bus.of_rb_data  = q.rb_data;
  assign bus.of_dst_addr = q.dst_addr;
  assign bus.of_dst_we_  = q.dst_we_;
  assign bus.of_is_load  = q.is_load;
  assign bus.stall_cnt   = cnt;

endmodule

// File: doc/yutorina_operand_fetch.md
Name: yutorina_operand_fetch

Overview:
Register-read side of the GPR in the Yutorina pipeline, sitting between decode and execute. Drives the GPR read ports and resolves the RAW hazards the GPR cannot: same-cycle write returns old data, and results are still in flight in EX/MEM. Forwards from EX, MEM and WB, detects load-use hazards and requests a decode hold. Registers operands into the ID/EX pipeline register with stall and flush, and counts load-use stall cycles.

Parameters:
GPR_NUM, 32, number of general-purpose registers
GPR_ADDR_W, 5, register address width (log2 GPR_NUM)
WORD_DATA_W, 32, data word width
STALL_CNT_W, 16, width of load-use stall counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
id_en  in  1  decode slot holds a valid instruction
id_ra_addr / id_rb_addr  in  GPR_ADDR_W  source register addresses
id_ra_use / id_rb_use  in  1  instruction actually reads ra/rb
id_dst_addr  in  GPR_ADDR_W  destination register
id_dst_we_  in  1  destination write enable, active-low
id_is_load  in  1  instruction is a load
gpr_rd_addr0 / gpr_rd_addr1  out  GPR_ADDR_W  GPR read addresses, equal to id_ra_addr / id_rb_addr
gpr_rd_data0 / gpr_rd_data1  in  WORD_DATA_W  GPR read data, combinational
ex_en, ex_dst_we_, ex_is_load  in  1  EX-stage valid, active-low write, load flag
ex_dst_addr  in  GPR_ADDR_W  EX destination
ex_fwd_data  in  WORD_DATA_W  EX ALU result
mem_en, mem_dst_we_  in  1  MEM-stage valid, active-low write
mem_dst_addr  in  GPR_ADDR_W; mem_fwd_data  in  WORD_DATA_W  MEM result, including load data
wb_we_  in  1; wb_addr  in  GPR_ADDR_W; wb_data  in  WORD_DATA_W  same signals as the GPR write port
stall  in  1  external hold of the ID/EX register
flush  in  1  kill the ID/EX contents
hazard_stall  out  1  load-use hazard: decode must hold, combinational
of_en  out  1  ID/EX valid
of_ra_data / of_rb_data  out  WORD_DATA_W  resolved operands
of_dst_addr  out  GPR_ADDR_W; of_dst_we_  out  1; of_is_load  out  1  passed-through control
stall_cnt  out  STALL_CNT_W  load-use stall cycle counter

Behaviour:
- Reset (rst low, async): of_en=0, of_ra_data=of_rb_data=0, of_dst_addr=0, of_dst_we_=1 (disabled), of_is_load=0, stall_cnt=0.
- Source match per operand (ra, rb independently). A stage "hits" when it is valid (WB: wb_we_==0), its write enable is 0 (asserted), its dst equals the source, and the source is nonzero.
- Operand priority: source==0 -> 0. Otherwise EX hit -> ex_fwd_data. Otherwise MEM hit -> mem_fwd_data. Otherwise WB hit -> wb_data. Otherwise the GPR read data.
- hazard_stall = id_en & ex_en & ex_is_load & (ex_dst_we_==0) & ex_dst_addr!=0 & ((id_ra_use & ra==ex_dst_addr) | (id_rb_use & rb==ex_dst_addr)).
- Register update, posedge, priority order:
  - flush: of_en=0, of_dst_we_=1.
  - else stall: hold all of_* registers.
  - else hazard_stall: insert a bubble (of_en=0, of_dst_we_=1; data don't-care but held).
  - else load id_* and the resolved operands; of_en=id_en.
- Latency: one cycle from decode to of_*.
- stall_cnt increments when hazard_stall & !stall & !flush. It saturates at all-ones and is cleared only by reset.
- Unused-operand hits do not raise hazard_stall.
- Writes to $0 are never forwarded.
- Reset mid-stall: the bubble state is lost and outputs return to reset values immediately.

Decomposition:
- Shared package: GprAddrBus, WordDataBus, GPR_ZERO, the ENABLE_/DISABLE_ active-low constants, and RESET_EDGE/RESET_ENABLE.
- Sub-module yutorina_fwd_mux: one combinational priority mux per operand, instantiated twice.

Test Plan:
- GPR r3=0x11 from reset, id ra=3, no hits -> next cycle of_ra_data=0x11, of_en=1.
- wb_we_=0, wb_addr=3, wb_data=0x22 in the same cycle as id ra=3 -> of_ra_data=0x22, not the stale 0x11.
- EX and MEM both write r5 (0xAA, 0xBB), id rb=5 -> of_rb_data=0xAA. Same case with ex_en=0 -> 0xBB.
- EX load to r7, id ra=7 with ra_use=1 -> hazard_stall=1, next of_en=0, stall_cnt=1. Following cycle MEM supplies 0x77 -> of_ra_data=0x77.
- EX write to r0=0xFF, id ra=0 -> of_ra_data=0, hazard_stall=0 even when EX is a load.
- stall=1 and flush=1 together -> of_en=0. Preload stall_cnt to 0xFFFF via repeated hazards -> stays 0xFFFF.
